// File: rtl/psum_accum3_if.sv
// psum_accum3_if
// Bundles the beat input and result output handshakes of psum_accum3.
//   in_valid / in_ready        : beat handshake, upstream -> accumulator
//   psum_in_0..2 (DATA_W)      : signed partial sums, lanes 0..2
//   out_valid / out_ready      : result handshake, accumulator -> downstream
//   acc_out_0..2 (ACC_W)       : signed accumulated results
//   ovf_out (3)                : per-lane overflow flag for the presented group
// Modports: slave = accumulator side, master = surrounding environment.
interface psum_accum3_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] psum_in_0;
    logic signed [DATA_W-1:0] psum_in_1;
    logic signed [DATA_W-1:0] psum_in_2;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  acc_out_0;
    logic signed [ACC_W-1:0]  acc_out_1;
    logic signed [ACC_W-1:0]  acc_out_2;
    logic [2:0]               ovf_out;

    modport slave (
        input  in_valid, psum_in_0, psum_in_1, psum_in_2, out_ready,
        output in_ready, out_valid, acc_out_0, acc_out_1, acc_out_2, ovf_out
    );

    modport master (
        output in_valid, psum_in_0, psum_in_1, psum_in_2, out_ready,
        input  in_ready, out_valid, acc_out_0, acc_out_1, acc_out_2, ovf_out
    );
endinterface

// File: rtl/psum_accum3.sv
// psum_accum3
// Three-lane partial-sum accumulator. Sums each lane's signed partial sums
// over a group of cfg_len beats (0 counts as 1) and holds the three results
// until the downstream handshake completes.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   cfg_len  : beats per group, sampled on the group's first accepted beat
//   busy     : a group is in progress or a result is held
//   bus      : psum_accum3_if.slave (beat input, result output, ovf_out)
// Optional feature: define PSUM_ACC_SAT_EN for saturating lane adds with
// sticky per-lane overflow flags; otherwise adds wrap and ovf_out is 0.
module psum_accum3 #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cfg_len,
    output logic             busy,
    psum_accum3_if.slave     bus
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc [3];
    logic signed [ACC_W-1:0] psum_ext [3];
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        len_q;
    logic [CNT_W-1:0]        len_eff;
    logic [CNT_W:0]          cnt_inc;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    busy_q;
    logic                    beat;

`ifdef PSUM_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [2:0] ovf;
`endif

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] x);
        return ACC_W'(x);
    endfunction

`ifdef PSUM_ACC_SAT_EN
    // Overflow when the carry-out disagrees with the result sign bit.
    function automatic logic lane_ovf(input logic signed [ACC_W-1:0] a,
                                      input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] wide;
        wide = (ACC_W+1)'(a) + (ACC_W+1)'(b);
        return wide[ACC_W] != wide[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] lane_add(input logic signed [ACC_W-1:0] a,
                                                         input logic signed [ACC_W-1:0] b);
        if (lane_ovf(a, b)) begin
            // Both operands share the sign of the true result on overflow.
            return a[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
        return a + b;
    endfunction
`else
    function automatic logic signed [ACC_W-1:0] lane_add(input logic signed [ACC_W-1:0] a,
                                                         input logic signed [ACC_W-1:0] b);
        return a + b;
    endfunction
`endif

    always_comb begin
        psum_ext[0] = sext(bus.psum_in_0);
        psum_ext[1] = sext(bus.psum_in_1);
        psum_ext[2] = sext(bus.psum_in_2);
    end

    assign beat    = bus.in_valid && in_ready_q;
    assign len_eff = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
    assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            len_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < 3; i++) acc[i] <= '0;
`ifdef PSUM_ACC_SAT_EN
            ovf         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (beat) begin
                        len_q  <= len_eff;
                        cnt    <= CNT_W'(1);
                        busy_q <= 1'b1;
                        for (int i = 0; i < 3; i++) acc[i] <= psum_ext[i];
`ifdef PSUM_ACC_SAT_EN
                        ovf    <= '0;
`endif
                        if (len_eff == CNT_W'(1)) begin
                            state       <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (beat) begin
                        cnt <= cnt_inc[CNT_W-1:0];
                        for (int i = 0; i < 3; i++) begin
                            acc[i] <= lane_add(acc[i], psum_ext[i]);
`ifdef PSUM_ACC_SAT_EN
                            ovf[i] <= ovf[i] | lane_ovf(acc[i], psum_ext[i]);
`endif
                        end
                        if (cnt_inc == {1'b0, len_q}) begin
                            state       <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = busy_q;
    assign bus.acc_out_0 = acc[0];
    assign bus.acc_out_1 = acc[1];
    assign bus.acc_out_2 = acc[2];
`ifdef PSUM_ACC_SAT_EN
    assign bus.ovf_out   = ovf;
`else
    assign bus.ovf_out   = 3'b000;
`endif

endmodule
